// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 receiver and key-state tracker: frames bytes off the raw pins, decodes
// make/break/extended sequences and keeps a held level per game control key.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] key_held,
  output logic [6:0] key_press,
  output logic [7:0] last_key,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fall_c;

  // Idle level of both PS/2 lines is high, so sync flops reset high to avoid a fake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync[0]  <= ps2_clk;
      data_sync[0] <= ps2_data;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      clk_prev <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall_c = clk_prev & ~clk_s;

  rx_state_t state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo;

  // Frame receiver; the stop-bit check is resolved on the stop edge so the pulse
  // is visible during the single CHECK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tmo        <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          tmo <= '0;
          if (fall_c && !data_s) begin
            state   <= SHIFT;
            bit_cnt <= 4'd0;
          end
        end
        SHIFT: begin
          if (fall_c) begin
            tmo     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              shreg <= {data_s, shreg[7:1]};
            end else if (bit_cnt == 4'd8) begin
              par_bit <= data_s;
            end else begin
              state <= CHECK;
              if (data_s && (^{shreg, par_bit})) begin
                byte_valid <= 1'b1;
                rx_byte    <= shreg;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        CHECK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] base_map(input logic [7:0] c);
    case (c)
      8'h1D:   return 7'b0000001;
      8'h1B:   return 7'b0000010;
      8'h1C:   return 7'b0000100;
      8'h23:   return 7'b0001000;
      8'h5A:   return 7'b0010000;
      8'h22:   return 7'b0100000;
      8'h1A:   return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [4:0] ext_map(input logic [7:0] c);
    case (c)
      8'h75:   return 5'b00001;
      8'h72:   return 5'b00010;
      8'h6B:   return 5'b00100;
      8'h74:   return 5'b01000;
      8'h5A:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  logic       brk_pend, ext_pend;
  logic [6:0] base_flag, base_nxt;
  logic [4:0] ext_flag, ext_nxt;
  logic [6:0] held_nxt;
  logic       code_c;

  assign code_c = byte_valid && (rx_byte != CODE_BRK) && (rx_byte != CODE_EXT);

  // Next key flags: plain and extended sources are tracked separately and ORed.
  always_comb begin
    base_nxt = base_flag;
    ext_nxt  = ext_flag;
    if (code_c) begin
      if (ext_pend) begin
        if (brk_pend) ext_nxt = ext_flag & ~ext_map(rx_byte);
        else          ext_nxt = ext_flag | ext_map(rx_byte);
      end else begin
        if (brk_pend) base_nxt = base_flag & ~base_map(rx_byte);
        else          base_nxt = base_flag | base_map(rx_byte);
      end
    end
    held_nxt = base_nxt | {2'b00, ext_nxt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_pend  <= 1'b0;
      ext_pend  <= 1'b0;
      base_flag <= 7'd0;
      ext_flag  <= 5'd0;
      key_held  <= 7'd0;
      key_press <= 7'd0;
      last_key  <= 8'h00;
    end else begin
      base_flag <= base_nxt;
      ext_flag  <= ext_nxt;
      key_held  <= held_nxt;
      key_press <= held_nxt & ~key_held;
      if (frame_err) begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == CODE_BRK) begin
          brk_pend <= 1'b1;
        end else if (rx_byte == CODE_EXT) begin
          ext_pend <= 1'b1;
        end else begin
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
          if (!brk_pend)                last_key <= rx_byte;
          else if (rx_byte == last_key) last_key <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus queues expected byte/error events with
// the key state that must follow them; a monitor pops and compares on each DUT event.
module tb_ps2_key_tracker;

  localparam int unsigned TMO  = 150;
  localparam int unsigned HALF = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [6:0] key_held;
  logic [6:0] key_press;
  logic [7:0] last_key;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  ps2_key_tracker #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_held(key_held), .key_press(key_press), .last_key(last_key),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] b;
    logic [6:0] held;
    logic [7:0] last;
    logic [6:0] press;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Drives the first nbits of a start/data/parity/stop frame, then idles.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    ps2_data = 1'b1;
    repeat (HALF * 3) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic [6:0] held, input logic [7:0] last,
                      input logic [6:0] press);
    q.push_back('{1'b0, b, held, last, press});
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic send_bad(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                          input logic [6:0] held, input logic [7:0] last);
    q.push_back('{1'b1, 8'h00, held, last, 7'h00});
    send_frame(b, bad_par, bad_stop, 11);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_held"},  8'(key_held),   8'h00);
    check({tag, "_press"}, 8'(key_press),  8'h00);
    check({tag, "_last"},  last_key,       8'h00);
    check({tag, "_valid"}, 8'(byte_valid), 8'h00);
    check({tag, "_rx"},    rx_byte,        8'h00);
    check({tag, "_err"},   8'(frame_err),  8'h00);
  endtask

  // Monitor: one queue entry per byte_valid/frame_err pulse, key state checked next cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      if (byte_valid || frame_err) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got valid=%b err=%b rx=%h, expected none",
                   byte_valid, frame_err, rx_byte);
        end else begin
          e = q.pop_front();
          check("event_kind", 8'({byte_valid, frame_err}), 8'({~e.err, e.err}));
          if (!e.err) check("rx_byte", rx_byte, e.b);
          @(negedge clk);
          check("key_held",  8'(key_held),  8'(e.held));
          check("last_key",  last_key,      e.last);
          check("key_press", 8'(key_press), 8'(e.press));
        end
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single make, typematic repeats, then break
    send(8'h1D, 7'h01, 8'h1D, 7'h01);
    send(8'h1D, 7'h01, 8'h1D, 7'h00);
    send(8'h1D, 7'h01, 8'h1D, 7'h00);
    send(8'hF0, 7'h01, 8'h1D, 7'h00);
    send(8'h1D, 7'h00, 8'h00, 7'h00);

    // overlapping plain and extended sources for the same key
    send(8'h1D, 7'h01, 8'h1D, 7'h01);
    send(8'h1A, 7'h41, 8'h1A, 7'h40);
    send(8'hE0, 7'h41, 8'h1A, 7'h00);
    send(8'h75, 7'h41, 8'h75, 7'h00);
    send(8'hF0, 7'h41, 8'h75, 7'h00);
    send(8'h1D, 7'h41, 8'h75, 7'h00);
    send(8'hF0, 7'h41, 8'h75, 7'h00);
    send(8'h1A, 7'h01, 8'h75, 7'h00);
    send(8'hE0, 7'h01, 8'h75, 7'h00);
    send(8'hF0, 7'h01, 8'h75, 7'h00);
    send(8'h75, 7'h00, 8'h00, 7'h00);

    // remaining key map entries and an unmapped code
    send(8'h1B, 7'h02, 8'h1B, 7'h02);
    send(8'hE0, 7'h02, 8'h1B, 7'h00);
    send(8'h74, 7'h0A, 8'h74, 7'h08);
    send(8'h1C, 7'h0E, 8'h1C, 7'h04);
    send(8'h23, 7'h0E, 8'h23, 7'h00);
    send(8'h22, 7'h2E, 8'h22, 7'h20);
    send(8'hE0, 7'h2E, 8'h22, 7'h00);
    send(8'h5A, 7'h3E, 8'h5A, 7'h10);
    send(8'h5A, 7'h3E, 8'h5A, 7'h00);
    send(8'h2C, 7'h3E, 8'h2C, 7'h00);

    // parity and stop errors; an error after F0 turns the following code into a make
    send_bad(8'h1B, 1'b1, 1'b0, 7'h3E, 8'h2C);
    send_bad(8'h1B, 1'b0, 1'b1, 7'h3E, 8'h2C);
    send(8'hF0, 7'h3E, 8'h2C, 7'h00);
    send_bad(8'h1C, 1'b1, 1'b0, 7'h3E, 8'h2C);
    send(8'h1C, 7'h3E, 8'h1C, 7'h00);

    // release everything
    send(8'hF0, 7'h3E, 8'h1C, 7'h00);
    send(8'h1B, 7'h3C, 8'h1C, 7'h00);
    send(8'hF0, 7'h3C, 8'h1C, 7'h00);
    send(8'h1C, 7'h38, 8'h00, 7'h00);
    send(8'hE0, 7'h38, 8'h00, 7'h00);
    send(8'hF0, 7'h38, 8'h00, 7'h00);
    send(8'h74, 7'h38, 8'h00, 7'h00);
    send(8'hF0, 7'h38, 8'h00, 7'h00);
    send(8'h23, 7'h30, 8'h00, 7'h00);
    send(8'hF0, 7'h30, 8'h00, 7'h00);
    send(8'h22, 7'h10, 8'h00, 7'h00);
    send(8'hF0, 7'h10, 8'h00, 7'h00);
    send(8'h5A, 7'h10, 8'h00, 7'h00);
    send(8'hE0, 7'h10, 8'h00, 7'h00);
    send(8'hF0, 7'h10, 8'h00, 7'h00);
    send(8'h5A, 7'h00, 8'h00, 7'h00);

    // stalled frame times out, next frame decodes
    q.push_back('{1'b1, 8'h00, 7'h00, 8'h00, 7'h00});
    send_frame(8'h5A, 1'b0, 1'b0, 5);
    repeat (TMO + 20) @(negedge clk);
    send(8'h5A, 7'h10, 8'h5A, 7'h10);

    // asynchronous reset in the middle of a frame
    send(8'hF0, 7'h10, 8'h5A, 7'h00);
    send(8'h5A, 7'h00, 8'h00, 7'h00);
    send(8'h22, 7'h20, 8'h22, 7'h20);
    send_frame(8'h1D, 1'b0, 1'b0, 4);
    #3 rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h1D, 7'h01, 8'h1D, 7'h01);

    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 8'(q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
